// File: rtl/key_scan_seq.sv
// rtl/key_scan_seq.sv - keypad matrix scan sequencer with per-key debounce and event FIFO
// One row is driven low at a time; columns are synchronised, debounced per key, and changes queued.
module key_scan_seq #(
   parameter int ROWS       = 2,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int DEB_CNT    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic [COLS-1:0] col_i,
   output logic [ROWS-1:0] row_o,
   output logic [7:0]      evt_o,
   output logic            evt_vld_o,
   input  logic            pop_i,
   output logic            int_o,
   output logic            ovf_o,
   input  logic            ovf_clr_i,
   output logic            busy_o
);
   localparam int KEYS = ROWS * COLS;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int KW   = (KEYS > 1) ? $clog2(KEYS) : 1;
   localparam int DW   = $clog2(SCAN_DIV);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [8:0]    DEB_C    = DEB_CNT[8:0];
   localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, NEXT} state_t;

   state_t          state;
   logic [RW-1:0]   r;
   logic [CW-1:0]   c;
   logic [DW-1:0]   div_cnt;
   logic [COLS-1:0] col_meta;
   logic [COLS-1:0] col_sync;
   logic [7:0]      deb [KEYS];
   logic [KEYS-1:0] stable;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;

   logic [KW-1:0]   key;
   logic [RW-1:0]   r_nxt;
   logic            raw;
   logic            fire;
   logic            full;
   logic            do_pop;
   logic            do_push;
   logic [7:0]      evt_new;

   always_comb begin
      key     = KW'(32'(r) * COLS + 32'(c));
      r_nxt   = (r == RW'(ROWS - 1)) ? '0 : r + 1'b1;
      raw     = ~col_sync[c];
      // a key commits on the sample that would make its run length reach DEB_CNT
      fire    = (state == SAMPLE) && (raw != stable[key]) &&
                (({1'b0, deb[key]} + 9'd1) == DEB_C);
      evt_new = {raw, 1'b0, 6'(key)};
      full    = (count == FULL_CNT);
      do_pop  = pop_i && (count != '0);
      do_push = fire && (!full || do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         col_meta <= '1;
         col_sync <= '1;
         state    <= IDLE;
         r        <= '0;
         c        <= '0;
         div_cnt  <= '0;
         row_o    <= '1;
         stable   <= '0;
         for (int i = 0; i < KEYS; i++) deb[i] <= '0;
      end else begin
         col_meta <= col_i;
         col_sync <= col_meta;
         case (state)
            IDLE: begin
               if (en_i) begin
                  state   <= DRIVE;
                  r       <= '0;
                  div_cnt <= '0;
                  row_o   <= ~ROWS'(1);
               end
            end
            DRIVE: begin
               if (div_cnt == DIV_LAST) begin
                  state   <= SAMPLE;
                  c       <= '0;
                  div_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (raw == stable[key]) begin
                  deb[key] <= '0;
               end else if (fire) begin
                  stable[key] <= raw;
                  deb[key]    <= '0;
               end else begin
                  deb[key] <= deb[key] + 8'd1;
               end
               if (c == CW'(COLS - 1)) begin
                  state <= NEXT;
                  row_o <= '1;
               end else begin
                  c <= c + 1'b1;
               end
            end
            NEXT: begin
               r <= r_nxt;
               if (en_i) begin
                  state   <= DRIVE;
                  div_cnt <= '0;
                  row_o   <= ~(ROWS'(1) << r_nxt);
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_o  <= 1'b0;
         busy_o <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= evt_new;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (fire && full && !do_pop) ovf_o <= 1'b1;
         else if (ovf_clr_i)          ovf_o <= 1'b0;
         busy_o <= |stable;
      end
   end

   assign evt_o     = mem[rd_ptr];
   assign evt_vld_o = (count != '0);
   assign int_o     = evt_vld_o;
endmodule

// File: tb/tb_key_scan_seq.sv
// tb/tb_key_scan_seq.sv - scoreboard bench for key_scan_seq with a keypad model and scan-level reference
// Key patterns change only between full scans; the model predicts each scan's events up front.
module tb_key_scan_seq;
   localparam int ROWS = 2, COLS = 4, SCAN_DIV = 4, DEB_CNT = 3, FIFO_DEPTH = 4;
   localparam int KEYS = ROWS * COLS;
   localparam int SLOT = SCAN_DIV + COLS + 1;
   localparam int SCAN_LEN = ROWS * SLOT;

   logic clk = 1'b0;
   logic rst_i, en_i, pop_i, ovf_clr_i;
   logic [COLS-1:0] col_i;
   logic [ROWS-1:0] row_o;
   logic [7:0] evt_o;
   logic evt_vld_o, int_o, ovf_o, busy_o;
   logic [KEYS-1:0] pressed;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q [$];
   logic [KEYS-1:0] model_stable;
   int model_deb [KEYS];
   int model_count;
   bit model_ovf;
   bit hold;
   bit mon_en;

   always #10 clk = ~clk;

   // passive keypad: a pressed key shorts its column to the row being driven low
   always_comb begin
      col_i = '1;
      for (int rr = 0; rr < ROWS; rr++)
         for (int cc = 0; cc < COLS; cc++)
            if (!row_o[rr] && pressed[rr*COLS+cc]) col_i[cc] = 1'b0;
   end

   key_scan_seq #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT),
                  .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .col_i(col_i), .row_o(row_o),
      .evt_o(evt_o), .evt_vld_o(evt_vld_o), .pop_i(pop_i), .int_o(int_o),
      .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i), .busy_o(busy_o));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [1:0] exp_row(input int i);
      int p;
      p = i % SLOT;
      if (p == SLOT - 1) return 2'b11;
      return ~(2'b01 << (i / SLOT));
   endfunction

   task automatic model_reset();
      model_stable = '0;
      for (int k = 0; k < KEYS; k++) model_deb[k] = 0;
      exp_q.delete();
      model_count = 0;
      model_ovf = 1'b0;
   endtask

   task automatic record_event(input logic [7:0] e);
      if (!hold) exp_q.push_back(e);
      else if (model_count == FIFO_DEPTH) model_ovf = 1'b1;
      else begin
         exp_q.push_back(e);
         model_count++;
      end
   endtask

   // called at the negedge just before a scan's first DRIVE edge
   task automatic run_scan(input logic [KEYS-1:0] keys, input int pop_key, input bit clr);
      bit prev_busy;
      int pop_cyc;
      logic [7:0] popped;
      pressed = keys;
      prev_busy = |model_stable;
      pop_cyc = -1;
      popped = '0;
      if (clr) begin
         ovf_clr_i = 1'b1;
         model_ovf = 1'b0;
      end
      if (pop_key >= 0) begin
         pop_cyc = SLOT * (pop_key / COLS) + SCAN_DIV + 1 + pop_key % COLS;
         popped = exp_q.pop_front();
         model_count--;
      end
      for (int k = 0; k < KEYS; k++) begin
         if (keys[k] == model_stable[k]) model_deb[k] = 0;
         else begin
            model_deb[k]++;
            if (model_deb[k] == DEB_CNT) begin
               model_stable[k] = keys[k];
               model_deb[k] = 0;
               record_event({keys[k], 1'b0, 6'(k)});
            end
         end
      end
      for (int i = 0; i < SCAN_LEN; i++) begin
         if (i == pop_cyc) begin
            check("pop_head", evt_o, popped);
            pop_i = 1'b1;
         end
         @(negedge clk);
         if (i == pop_cyc) pop_i = 1'b0;
         if (i == 0) begin
            ovf_clr_i = 1'b0;
            check("busy", busy_o, prev_busy);
         end
         check("row_walk", row_o, exp_row(i));
      end
      check("ovf", ovf_o, model_ovf);
      if (hold) begin
         check("vld", evt_vld_o, model_count > 0);
         check("int", int_o, model_count > 0);
      end
   endtask

   task automatic drain(input logic [KEYS-1:0] keys);
      hold = 1'b0;
      model_count = 0;
      mon_en = 1'b1;
      run_scan(keys, -1, 1'b0);
      check("drain_left", exp_q.size(), 0);
      check("drain_vld", evt_vld_o, 0);
      check("drain_int", int_o, 0);
   endtask

   task automatic idle_gap(input int n);
      en_i = 1'b0;
      repeat (n) begin
         @(negedge clk);
         check("idle_row", row_o, 2'b11);
      end
      en_i = 1'b1;
   endtask

   task automatic monitor();
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (mon_en && rst_i) begin
            if (evt_vld_o) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_evt: got %02h, none expected", evt_o);
               end else begin
                  e = exp_q.pop_front();
                  check("evt", evt_o, e);
               end
               pop_i = 1'b1;
            end else begin
               pop_i = 1'b0;
            end
         end
      end
   endtask

   initial begin
      logic [KEYS-1:0] pat;
      rst_i = 1'b0; en_i = 1'b0; pop_i = 1'b0; ovf_clr_i = 1'b0;
      pressed = '0; mon_en = 1'b0; hold = 1'b0;
      model_reset();
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      check("rst_row", row_o, 2'b11);
      check("rst_vld", evt_vld_o, 0);
      check("rst_int", int_o, 0);
      check("rst_ovf", ovf_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_evt", evt_o, 8'h00);
      rst_i = 1'b1;
      @(negedge clk);
      check("idle_row", row_o, 2'b11);
      en_i = 1'b1;

      hold = 1'b1;
      repeat (3) run_scan(8'h40, -1, 1'b0);
      check("press_evt", evt_o, 8'h86);
      check("press_busy", busy_o, 1);
      drain(8'h40);
      repeat (3) run_scan(8'h00, -1, 1'b0);

      repeat (2) run_scan(8'h02, -1, 1'b0);
      repeat (3) run_scan(8'h00, -1, 1'b0);

      hold = 1'b1; mon_en = 1'b0; pop_i = 1'b0;
      repeat (3) run_scan(8'h1F, -1, 1'b0);
      check("ovf_set", ovf_o, 1);
      run_scan(8'h1F, -1, 1'b1);
      check("ovf_cleared", ovf_o, 0);
      drain(8'h1F);

      hold = 1'b1; mon_en = 1'b0; pop_i = 1'b0;
      repeat (3) run_scan(8'h10, -1, 1'b0);
      repeat (2) run_scan(8'h90, -1, 1'b0);
      run_scan(8'h90, 7, 1'b0);
      drain(8'h90);
      repeat (3) run_scan(8'h00, -1, 1'b0);

      repeat (2) run_scan(8'h20, -1, 1'b0);
      repeat (SLOT + SCAN_DIV + 2) @(negedge clk);
      rst_i = 1'b0;
      #1;
      model_reset();
      pop_i = 1'b0;
      check("mid_rst_row", row_o, 2'b11);
      check("mid_rst_vld", evt_vld_o, 0);
      check("mid_rst_int", int_o, 0);
      check("mid_rst_ovf", ovf_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_evt", evt_o, 8'h00);
      @(negedge clk);
      rst_i = 1'b1;
      repeat (3) run_scan(8'h20, -1, 1'b0);
      drain(8'h20);

      pat = 8'h20;
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < KEYS; k++)
            if ($urandom_range(0, 4) == 0) pat[k] = ~pat[k];
         if ($urandom_range(0, 7) == 0) idle_gap(int'($urandom_range(1, 4)));
         run_scan(pat, -1, 1'b0);
      end
      repeat (DEB_CNT) run_scan(pat, -1, 1'b0);
      drain(pat);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
